// File: rtl/bridge_pkg.sv
// Shared widths, request-packet field positions and sink FSM encoding
// for the sink side of the bridge.
package bridge_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int PACKET_WIDTH = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int RSP_WIDTH    = DATA_WIDTH + 1;

  // Request packet layout, MSB first: {rd0_wr1, valid, addr, wr_data}
  localparam int PKT_DATA_LSB  = 0;
  localparam int PKT_ADDR_LSB  = DATA_WIDTH;
  localparam int PKT_VALID_BIT = ADDR_WIDTH + DATA_WIDTH;
  localparam int PKT_RW_BIT    = ADDR_WIDTH + DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_PUSH_RSP = 3'd3,
    S_SLEEP    = 3'd4
  } sink_state_e;

endpackage

// File: rtl/sink_controller.sv
// Sink-side bridge controller: pops request packets from a FWFT FIFO, runs
// them on the master port and pushes read responses into the response FIFO.
module sink_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = bridge_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = bridge_pkg::DATA_WIDTH,
  parameter int PACKET_WIDTH = bridge_pkg::PACKET_WIDTH
) (
  input  logic                    i_clk_sink,
  input  logic                    i_rstn_sink,
  input  logic                    i_sink_sleep_req,
  output logic                    o_sink_sleep_ack,
  input  logic                    source_sleep_status,
  output logic                    sink_sleep_status,
  input  logic [PACKET_WIDTH-1:0] i_packet,
  input  logic                    req_fifo_empty,
  output logic                    req_fifo_rd_en,
  output logic [DATA_WIDTH:0]     o_rsp_packet,
  input  logic                    rsp_fifo_full,
  output logic                    rsp_fifo_wr_en,
  output logic                    rd0_wr1,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    valid,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    ready,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_valid,
  output sink_state_e             o_dbg_state
);

  // Master handshake: valid rises the cycle after the pop and holds
  // rd0_wr1/addr/wr_data steady; the transfer happens in the first cycle
  // with valid && ready, after which valid drops.

  sink_state_e           state_q, state_d;
  logic                  rd0_wr1_q, rd0_wr1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH:0]   rsp_q, rsp_d;

  logic sleep_pend;
  logic pop_c;
  logic push_c;

  assign sleep_pend = i_sink_sleep_req | source_sleep_status;

  always_comb begin
    state_d           = state_q;
    rd0_wr1_d         = rd0_wr1_q;
    addr_d            = addr_q;
    wr_data_d         = wr_data_q;
    rsp_d             = rsp_q;
    pop_c             = 1'b0;
    push_c            = 1'b0;
    valid             = 1'b0;
    o_rsp_packet      = rsp_q;
    sink_sleep_status = 1'b0;
    o_sink_sleep_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Drain queued packets before honouring any sleep request.
        if (!req_fifo_empty) begin
          pop_c = 1'b1;
          if (i_packet[PKT_VALID_BIT]) begin
            rd0_wr1_d = i_packet[PKT_RW_BIT];
            addr_d    = i_packet[PKT_ADDR_LSB +: ADDR_WIDTH];
            wr_data_d = i_packet[PKT_DATA_LSB +: DATA_WIDTH];
            state_d   = S_ISSUE;
          end
        end else if (sleep_pend) begin
          state_d = S_SLEEP;
        end
      end
      S_ISSUE: begin
        valid = 1'b1;
        if (ready) state_d = rd0_wr1_q ? S_IDLE : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (rd_valid) begin
          rsp_d = {1'b1, rd_data};
          if (!rsp_fifo_full) begin
            push_c       = 1'b1;
            o_rsp_packet = {1'b1, rd_data};
            state_d      = S_IDLE;
          end else begin
            state_d = S_PUSH_RSP;
          end
        end
      end
      S_PUSH_RSP: begin
        if (!rsp_fifo_full) begin
          push_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SLEEP: begin
        sink_sleep_status = 1'b1;
        o_sink_sleep_ack  = i_sink_sleep_req;
        if (!sleep_pend) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by reset so the reset cycle can never pop or push.
  assign req_fifo_rd_en = pop_c & i_rstn_sink;
  assign rsp_fifo_wr_en = push_c & i_rstn_sink;

  always_ff @(posedge i_clk_sink) begin
    if (!i_rstn_sink) begin
      state_q   <= S_IDLE;
      rd0_wr1_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd0_wr1_q <= rd0_wr1_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rsp_q     <= rsp_d;
    end
  end

  assign rd0_wr1     = rd0_wr1_q;
  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sink_controller.sv
// Self-checking bench for sink_controller with FIFO and master models.
module tb_sink_controller;
  import bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 66;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, sleep_req, src_sleep, sleep_ack, sleep_status;
  logic [PW-1:0] packet;
  logic          empty, rd_en, full, wr_en;
  logic [DW:0]   rsp_pkt;
  logic          rd0_wr1, valid, ready, rd_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  sink_state_e   dbg_state;

  sink_controller dut (
    .i_clk_sink(clk), .i_rstn_sink(rstn),
    .i_sink_sleep_req(sleep_req), .o_sink_sleep_ack(sleep_ack),
    .source_sleep_status(src_sleep), .sink_sleep_status(sleep_status),
    .i_packet(packet), .req_fifo_empty(empty), .req_fifo_rd_en(rd_en),
    .o_rsp_packet(rsp_pkt), .rsp_fifo_full(full), .rsp_fifo_wr_en(wr_en),
    .rd0_wr1(rd0_wr1), .addr(addr), .valid(valid), .wr_data(wr_data),
    .ready(ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [PW-1:0] pkt_q[$];
  logic [PW-1:0] exp_txn_q[$];
  logic [PW-1:0] obs_txn_q[$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   obs_rsp_q[$];

  int cyc, pops, bad_pop, bad_push, unstable, sleep_busy, valid_total;
  int last_pop_cyc, first_valid_cyc, push_cyc, rdv_cyc, valid_run, last_valid_run;
  bit valid_prev, pop_pend, held_v, rd_pend, rand_mode;
  logic [PW-1:0] held;
  int ready_lat, rdv_lat, full_cycles, vcnt, wcnt, fcnt;
  logic [DW-1:0] fixed_rd_data;

  function automatic logic [PW-1:0] mk_pkt(logic rw, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    return {rw, v, a, d};
  endfunction

  task automatic refresh_req();
    logic [95:0] g;
    g = {$urandom(), $urandom(), $urandom()};
    empty  = (pkt_q.size() == 0);
    packet = empty ? g[PW-1:0] : pkt_q[0];
  endtask

  // Reads are compared without wr_data, which is meaningless for them.
  task automatic add_pkt(logic rw, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    pkt_q.push_back(mk_pkt(rw, v, a, d));
    if (v) exp_txn_q.push_back(mk_pkt(rw, 1'b1, a, rw ? d : '0));
    refresh_req();
  endtask

  task automatic clear_env();
    vcnt = 0; wcnt = 0; fcnt = 0; rd_pend = 0; held_v = 0; pop_pend = 0;
    ready = 0; rd_valid = 0; full = 0; rd_data = '0;
  endtask

  task automatic clear_stats();
    exp_txn_q.delete(); obs_txn_q.delete(); exp_q.delete(); obs_rsp_q.delete();
    pops = 0; bad_pop = 0; bad_push = 0; unstable = 0; sleep_busy = 0; valid_total = 0;
    last_pop_cyc = -1; first_valid_cyc = -1; push_cyc = -1; rdv_cyc = -1;
    valid_run = 0; last_valid_run = 0;
  endtask

  // One clock: drive master/rsp-FIFO inputs and sample at negedge,
  // apply FIFO pops after the posedge. Returns 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (valid) vcnt++;
    ready = valid && (vcnt > ready_lat);
    rd_valid = 1'b0;
    if (rd_pend) begin
      wcnt++;
      if (wcnt == rdv_lat) begin
        rd_valid = 1'b1;
        rd_data  = rand_mode ? DW'($urandom()) : fixed_rd_data;
        exp_q.push_back({1'b1, rd_data});
        rd_pend = 0;
        fcnt    = full_cycles;
        rdv_cyc = cyc;
      end
    end
    if (rand_mode) full = ($urandom_range(0, 2) == 0);
    else           full = (fcnt > 0);
    if (fcnt > 0) fcnt--;
    #1;
    if (rd_en) begin
      if (empty) bad_pop++;
      pops++; pop_pend = 1; last_pop_cyc = cyc;
    end
    if (wr_en) begin
      if (full) bad_push++;
      obs_rsp_q.push_back(rsp_pkt);
      push_cyc = cyc;
    end
    if (sleep_status && (valid || rd_en || wr_en)) sleep_busy++;
    if (valid && !valid_prev) first_valid_cyc = cyc;
    valid_prev = valid;
    if (valid) begin
      valid_total++; valid_run++;
      if (held_v && (mk_pkt(rd0_wr1, 1'b1, addr, wr_data) != held)) unstable++;
      held = mk_pkt(rd0_wr1, 1'b1, addr, wr_data); held_v = 1;
      if (ready) begin
        obs_txn_q.push_back(mk_pkt(rd0_wr1, 1'b1, addr, rd0_wr1 ? wr_data : '0));
        held_v = 0; vcnt = 0; last_valid_run = valid_run; valid_run = 0;
        if (!rd0_wr1) begin rd_pend = 1; wcnt = 0; end
        if (rand_mode) begin
          ready_lat = $urandom_range(0, 3);
          rdv_lat   = $urandom_range(1, 4);
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop_pend) begin
      void'(pkt_q.pop_front());
      pop_pend = 0;
    end
    refresh_req();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 0; sleep_req = 0; src_sleep = 0; rand_mode = 0;
    ready_lat = 0; rdv_lat = 1; full_cycles = 0; fixed_rd_data = '0;
    clear_env(); clear_stats(); refresh_req();
    tick(); tick();
    checks++;
    if ({valid, rd0_wr1, addr, wr_data, rd_en, wr_en, rsp_pkt, sleep_status, sleep_ack} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b rw=%b a=%h d=%h pop=%b push=%b rsp=%h st=%b ack=%b exp all 0",
               valid, rd0_wr1, addr, wr_data, rd_en, wr_en, rsp_pkt, sleep_status, sleep_ack);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    rstn = 1;
  endtask

  task automatic test_write();
    clear_stats(); ready_lat = 2;
    add_pkt(1'b1, 1'b1, 32'h0000_1000, 32'hA5A5_5A5A);
    for (int i = 0; i < 20 && obs_txn_q.size() == 0; i++) tick();
    tick(); tick();
    checks++;
    if (obs_txn_q.size() != 1 || obs_txn_q[0] !== exp_txn_q[0]) begin
      errors++; $display("FAIL write_txn got n=%0d %h exp %h", obs_txn_q.size(), obs_txn_q[0], exp_txn_q[0]);
    end
    checks++;
    if (first_valid_cyc != last_pop_cyc + 1) begin
      errors++; $display("FAIL write_latency got valid@%0d exp %0d", first_valid_cyc, last_pop_cyc + 1);
    end
    checks++;
    if (last_valid_run != 3 || unstable != 0) begin
      errors++; $display("FAIL write_hold got %0d cycles unstable=%0d exp 3 / 0", last_valid_run, unstable);
    end
    checks++;
    if (obs_rsp_q.size() != 0 || pops != 1) begin
      errors++; $display("FAIL write_nopush got pushes=%0d pops=%0d exp 0 / 1", obs_rsp_q.size(), pops);
    end
    checks++;
    if (dbg_state !== S_IDLE || valid !== 1'b0) begin
      errors++; $display("FAIL write_idle got state=%0d valid=%b exp 0 / 0", dbg_state, valid);
    end
  endtask

  task automatic test_read(input int fcyc, input string tag);
    clear_stats(); ready_lat = 0; rdv_lat = 3; full_cycles = fcyc;
    fixed_rd_data = 32'h1234_5678;
    add_pkt(1'b0, 1'b1, 32'h0000_2000, DW'($urandom()));
    for (int i = 0; i < 30 && obs_rsp_q.size() == 0; i++) tick();
    tick(); tick(); tick();
    checks++;
    if (obs_txn_q.size() != 1 || obs_txn_q[0] !== exp_txn_q[0]) begin
      errors++; $display("FAIL %s_txn got n=%0d %h exp %h", tag, obs_txn_q.size(), obs_txn_q[0], exp_txn_q[0]);
    end
    checks++;
    if (obs_rsp_q.size() != 1 || obs_rsp_q[0] !== {1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL %s_rsp got n=%0d %h exp 1 x %h", tag, obs_rsp_q.size(), obs_rsp_q[0], {1'b1, 32'h1234_5678});
    end
    checks++;
    if (push_cyc != rdv_cyc + fcyc || bad_push != 0) begin
      errors++; $display("FAIL %s_push_time got @%0d bad=%0d exp @%0d bad=0", tag, push_cyc, bad_push, rdv_cyc + fcyc);
    end
    full_cycles = 0;
  endtask

  task automatic test_sleep();
    clear_stats(); ready_lat = 1;
    add_pkt(1'b1, 1'b1, 32'h0000_0040, DW'($urandom()));
    add_pkt(1'b1, 1'b1, 32'h0000_0044, DW'($urandom()));
    tick(); tick();
    sleep_req = 1;
    for (int i = 0; i < 40 && dbg_state != S_SLEEP; i++) tick();
    checks++;
    if (obs_txn_q.size() != 2 || obs_txn_q[0] !== exp_txn_q[0] || obs_txn_q[1] !== exp_txn_q[1]) begin
      errors++; $display("FAIL sleep_drain got n=%0d exp 2 in order", obs_txn_q.size());
    end
    checks++;
    if (dbg_state !== S_SLEEP || sleep_status !== 1'b1 || sleep_ack !== 1'b1) begin
      errors++; $display("FAIL sleep_enter got state=%0d st=%b ack=%b exp %0d/1/1", dbg_state, sleep_status, sleep_ack, S_SLEEP);
    end
    tick(); tick(); tick();
    checks++;
    if (sleep_busy != 0 || sleep_status !== 1'b1) begin
      errors++; $display("FAIL sleep_quiet got busy=%0d st=%b exp 0 / 1", sleep_busy, sleep_status);
    end
    sleep_req = 0;
    #1;
    checks++;
    if (sleep_ack !== 1'b0) begin errors++; $display("FAIL sleep_ack_drop got %b exp 0", sleep_ack); end
    tick();
    checks++;
    if (dbg_state !== S_IDLE || sleep_status !== 1'b0) begin
      errors++; $display("FAIL sleep_exit got state=%0d st=%b exp 0 / 0", dbg_state, sleep_status);
    end
    src_sleep = 1;
    tick(); tick();
    checks++;
    if (sleep_status !== 1'b1 || sleep_ack !== 1'b0) begin
      errors++; $display("FAIL src_sleep got st=%b ack=%b exp 1 / 0", sleep_status, sleep_ack);
    end
    src_sleep = 0;
    tick();
  endtask

  task automatic test_invalid_and_reset();
    int pops_before, qsize_before;
    clear_stats(); ready_lat = 0;
    add_pkt(1'b1, 1'b0, DW'($urandom()), DW'($urandom()));
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pops != 1 || valid_total != 0 || obs_txn_q.size() != 0) begin
      errors++; $display("FAIL invalid_pkt got pops=%0d valid_cycles=%0d txns=%0d exp 1/0/0", pops, valid_total, obs_txn_q.size());
    end
    clear_stats(); ready_lat = 10;
    add_pkt(1'b1, 1'b1, 32'h0000_3000, DW'($urandom()));
    for (int i = 0; i < 10 && dbg_state != S_ISSUE; i++) tick();
    add_pkt(1'b0, 1'b1, 32'h0000_3004, '0);
    pops_before = pops; qsize_before = pkt_q.size();
    rstn = 0;
    tick();
    checks++;
    if ({valid, rd0_wr1, addr, wr_data, rd_en, wr_en, rsp_pkt, sleep_status, sleep_ack} !== '0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL midreset_outputs got v=%b a=%h pop=%b push=%b state=%0d exp all 0", valid, addr, rd_en, wr_en, dbg_state);
    end
    checks++;
    if (pops != pops_before || pkt_q.size() != qsize_before || obs_rsp_q.size() != 0) begin
      errors++; $display("FAIL midreset_nopop got pops=%0d q=%0d push=%0d exp %0d/%0d/0", pops, pkt_q.size(), obs_rsp_q.size(), pops_before, qsize_before);
    end
    pkt_q.delete(); refresh_req(); clear_env(); clear_stats();
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_random();
    int added = 0;
    clear_stats(); rand_mode = 1; ready_lat = 1; rdv_lat = 2;
    for (int i = 0; i < 4000; i++) begin
      if (added < 40 && $urandom_range(0, 3) == 0) begin
        add_pkt(1'(($urandom_range(0, 1))), ($urandom_range(0, 7) != 0), AW'($urandom()), DW'($urandom()));
        added++;
      end
      if ($urandom_range(0, 29) == 0) sleep_req = ~sleep_req;
      tick();
      if (added == 40 && pkt_q.size() == 0 && !rd_pend && dbg_state == S_IDLE &&
          obs_txn_q.size() == exp_txn_q.size() && obs_rsp_q.size() == exp_q.size()) break;
    end
    sleep_req = 0; tick(); tick();
    checks++;
    if (pkt_q.size() != 0 || pops != 40 || bad_pop != 0) begin
      errors++; $display("FAIL rand_pops got left=%0d pops=%0d bad=%0d exp 0/40/0", pkt_q.size(), pops, bad_pop);
    end
    checks++;
    if (obs_txn_q.size() != exp_txn_q.size()) begin
      errors++; $display("FAIL rand_txn_count got %0d exp %0d", obs_txn_q.size(), exp_txn_q.size());
    end
    for (int i = 0; i < exp_txn_q.size() && i < obs_txn_q.size(); i++) begin
      checks++;
      if (obs_txn_q[i] !== exp_txn_q[i]) begin
        errors++; $display("FAIL rand_txn[%0d] got %h exp %h", i, obs_txn_q[i], exp_txn_q[i]);
      end
    end
    checks++;
    if (obs_rsp_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_rsp_count got %0d exp %0d", obs_rsp_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_rsp_q.size(); i++) begin
      checks++;
      if (obs_rsp_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_rsp[%0d] got %h exp %h", i, obs_rsp_q[i], exp_q[i]);
      end
    end
    checks++;
    if (bad_push != 0 || unstable != 0 || sleep_busy != 0) begin
      errors++; $display("FAIL rand_protocol got full_push=%0d unstable=%0d sleep_busy=%0d exp 0/0/0", bad_push, unstable, sleep_busy);
    end
    rand_mode = 0;
  endtask

  initial begin
    cyc = 0; valid_prev = 0; held = '0;
    test_reset();
    test_write();
    test_read(0, "read");
    test_read(4, "read_full");
    test_sleep();
    test_invalid_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sink_controller.md
SINK_CONTROLLER -- requirements
Module: sink_controller

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; PACKET_WIDTH, 66, request packet width.
REQ-002 Ports SHALL be (name direction width meaning): i_clk_sink in 1 sink-domain clock; i_rstn_sink in 1 reset.
REQ-003 i_rstn_sink SHALL be synchronous, active-low, sampled on rising i_clk_sink; one clock only.
REQ-004 i_sink_sleep_req in 1 local sleep request; o_sink_sleep_ack out 1 sleep acknowledge.
REQ-005 source_sleep_status in 1 far-side sleeping; sink_sleep_status out 1 this side sleeping.
REQ-006 i_packet in PACKET_WIDTH req-FIFO head, layout {rd0_wr1, valid, addr, wr_data}; req_fifo_empty in 1; req_fifo_rd_en out 1 pop.
REQ-007 o_rsp_packet out DATA_WIDTH+1 {rd_valid, rd_data}; rsp_fifo_full in 1; rsp_fifo_wr_en out 1 push.
REQ-008 Master side: rd0_wr1 out 1; addr out ADDR_WIDTH; valid out 1; wr_data out DATA_WIDTH; ready in 1; rd_data in DATA_WIDTH; rd_valid in 1.

Function
REQ-009 Req FIFO SHALL be first-word-fall-through; i_packet valid whenever req_fifo_empty=0.
REQ-010 FSM states SHALL be IDLE, ISSUE, WAIT_RD, PUSH_RSP, SLEEP.
REQ-011 sleep_pend SHALL equal i_sink_sleep_req OR source_sleep_status.
REQ-012 IDLE, req_fifo_empty=0: req_fifo_rd_en=1 for exactly one cycle; if packet valid bit=1 latch rd0_wr1/addr/wr_data into output regs, go ISSUE; if valid bit=0 discard packet, stay IDLE.
REQ-013 IDLE, req_fifo_empty=1, sleep_pend=1: go SLEEP; packets present SHALL be drained before sleeping.
REQ-014 ISSUE: valid=1, rd0_wr1/addr/wr_data held stable until cycle with ready=1; then write -> IDLE, read -> WAIT_RD.
REQ-015 Latency: packet at head in IDLE -> valid=1 on next cycle.
REQ-016 WAIT_RD: valid=0; on rd_valid=1 capture rd_data into response reg; if rsp_fifo_full=0 same cycle rsp_fifo_wr_en=1, o_rsp_packet={1,rd_data}, go IDLE; if full go PUSH_RSP.
REQ-017 PUSH_RSP: rsp_fifo_wr_en=1 with held {1,captured data} in first cycle rsp_fifo_full=0, then IDLE; never push while full.
REQ-018 rsp_fifo_wr_en SHALL assert exactly once per read, never for writes.
REQ-019 req_fifo_rd_en SHALL never assert when req_fifo_empty=1 or outside IDLE.
REQ-020 Sleep requests outside IDLE SHALL not abort in-flight transactions; honoured on return to IDLE.
REQ-021 SLEEP: sink_sleep_status=1; o_sink_sleep_ack=i_sink_sleep_req; no FIFO or master activity; exit to IDLE when sleep_pend=0.
REQ-022 Outside SLEEP: sink_sleep_status=0, o_sink_sleep_ack=0.
REQ-023 valid, req_fifo_rd_en, rsp_fifo_wr_en SHALL be 0 in any state not granting them above.

Reset
REQ-024 On i_rstn_sink=0 at clock edge: state IDLE; valid, rd0_wr1, addr, wr_data, req_fifo_rd_en, rsp_fifo_wr_en, o_rsp_packet, sink_sleep_status, o_sink_sleep_ack all 0.
REQ-025 Reset mid-ISSUE/WAIT_RD/PUSH_RSP SHALL abandon the transaction without push or pop; no packet consumed by the reset cycle.

Structure
REQ-026 Shared package bridge_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, PACKET_WIDTH, RSP_WIDTH, packet field bit positions, sink FSM state encoding.
REQ-027 Single module, no sub-module; FIFOs and CDC are external.

Verification
REQ-028 Write {1,1,0x0000_1000,0xA5A5_5A5A}, ready=1 after 2 cycles -> valid 1 cycle after pop, held 3 cycles, no rsp push, back IDLE.
REQ-029 Read {0,1,0x0000_2000,x}, rd_valid=1 rd_data=0x1234_5678 3 cycles later, FIFO not full -> one push {1,0x1234_5678} same cycle.
REQ-030 Same read with rsp_fifo_full=1 for 4 cycles at rd_valid -> PUSH_RSP, single push on cycle full drops, data intact.
REQ-031 Two packets queued, i_sink_sleep_req=1 during first -> both executed, then SLEEP, sink_sleep_status=1, ack=1; deassert -> IDLE next cycle, ack=0.
REQ-032 Packet valid bit=0 -> popped once, valid never asserts; reset asserted mid-ISSUE -> all outputs 0 next edge, no push/pop.
